// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Summary  : Pops bytes from an upstream FIFO and sends them as 8N1 UART
//            frames, with an optional even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        rd,
    output logic        txd,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frame_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t         state;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [CW-1:0]  baud;
    logic [2:0]     idx;
    logic           bit_end;
    logic           can_pop;

    assign bit_end = (baud == BAUD_LAST);
    assign can_pop = enable & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= 8'h00;
            par_bit     <= 1'b0;
            baud        <= '0;
            idx         <= 3'd0;
            rd          <= 1'b0;
            txd         <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            rd      <= 1'b0;
            tx_done <= 1'b0;

            // The baud counter only runs while a line bit is on the wire
            if (state == START || state == DATA || state == PARITY || state == STOP) begin
                baud <= bit_end ? '0 : baud + 1'b1;
            end

            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (can_pop) begin
                        state <= POP;
                        rd    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // Parity is latched here because the shift register is consumed
                    shreg   <= fifo_data;
                    par_bit <= ^fifo_data;
                    baud    <= '0;
                    idx     <= 3'd0;
                    txd     <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        txd   <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == 3'd7) begin
                            if (PARITY_EN) begin
                                txd   <= par_bit;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            idx   <= idx + 3'd1;
                            shreg <= shreg >> 1;
                            txd   <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done     <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (can_pop) begin
                            state <= POP;
                            rd    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per serial bit; legal range 2..1024.
REQ-002 Parameter PARITY_EN, default 0, SHALL insert an even-parity bit after the data bits when 1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  permits starting new frames when high.
REQ-006 fifo_empty  input  1  empty flag from the upstream 8-bit FIFO.
REQ-007 fifo_data  input  8  upstream FIFO read data, valid the cycle after rd.
REQ-008 rd  output  1  single-cycle pop strobe to the upstream FIFO.
REQ-009 txd  output  1  serial line, idle high.
REQ-010 busy  output  1  high from the pop cycle through the last stop-bit cycle.
REQ-011 tx_done  output  1  one-cycle pulse after each completed frame.
REQ-012 frame_count  output  16  count of completed frames, wraps.

Function
REQ-013 The block SHALL be an FSM with states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE: txd=1, rd=0; if enable=1 and fifo_empty=0, go to POP.
REQ-015 POP: rd=1 for exactly one cycle; unconditionally go to LOAD.
REQ-016 LOAD: capture fifo_data into the 8-bit shift register, clear the baud counter, go to START.
REQ-017 rd SHALL never assert while fifo_empty=1 at the same edge, and SHALL never assert outside POP.
REQ-018 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit index tracks the bit.
REQ-020 After bit 7, go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-021 PARITY: txd = XOR of the 8 captured bits for CLKS_PER_BIT cycles, then STOP.
REQ-022 STOP: txd=1 for CLKS_PER_BIT cycles.
REQ-023 On the last STOP cycle, tx_done SHALL pulse for one cycle, frame_count SHALL increment by 1, and the next state SHALL be POP if enable=1 and fifo_empty=0, otherwise IDLE.
REQ-024 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 at every bit boundary.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-026 Changes on fifo_data outside LOAD SHALL NOT affect txd.
REQ-027 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT line cycles plus 2 cycles of POP/LOAD overhead.
REQ-028 Back-to-back frames SHALL have exactly 2 cycles of extra idle-high between the stop bit and the next start bit.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On rst_n=0 at a clock edge: state=IDLE, txd=1, rd=0, busy=0, tx_done=0, frame_count=0, shift register=0, counters=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: txd=1 from the next edge, and frame_count SHALL NOT increment.

Verification (CLKS_PER_BIT=4, PARITY_EN=0 unless stated)
REQ-032 FIFO holds 0xA5, enable=1 -> one rd pulse; txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses once; frame_count=1.
REQ-033 FIFO holds 0x01..0x10 (16 bytes) -> 16 rd pulses; 16 frames decode in order 0x01..0x10; 2 idle cycles between frames; frame_count=16; no rd once fifo_empty=1.
REQ-034 PARITY_EN=1, byte 0x07 -> parity bit = 1; frame is 44 line cycles.
REQ-035 enable dropped during bit 3 with 2 bytes queued -> current frame completes; no second rd until enable=1 again.
REQ-036 rst_n=0 for 1 cycle during DATA bit 5 -> txd=1 the next cycle; busy=0; frame_count unchanged; the next byte is transmitted cleanly after reset.
REQ-037 fifo_empty=1 with enable=1 for 100 cycles -> rd never asserts; txd stays at 1.
